// File: rtl/config_pkg.sv
// Minimal core-configuration package: just enough of the configuration record
// for blocks that take a CVA6Cfg parameter to elaborate standalone.
// Ports: none (package only).
package config_pkg;

    typedef struct packed {
        logic [31:0] xlen;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/issue_queue.sv
// Purpose: circular FIFO of decoded instructions between ID and issue, with a cap
//          on simultaneously queued control-flow instructions.
// Latency: 1 cycle enqueue-to-head, no bypass. Backpressure: ack drops when full,
//          flushing, in reset, or a control-flow entry would exceed MaxCtrlFlow.
// Ports:   clk_i/rst_i (sync active-high), flush_i, stall_i; ID side decoded_instr_i,
//          orig_instr_i, is_ctrl_flow_i, decoded_instr_valid_i/decoded_instr_ack_o;
//          issue side issue_instr_o, orig_instr_o, is_ctrl_flow_o,
//          issue_instr_valid_o/issue_ack_i; status count_o, ctrl_flow_pending_o.
module issue_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
    parameter type                   scoreboard_entry_t = logic,
    parameter int unsigned           Depth       = 4,
    parameter int unsigned           MaxCtrlFlow = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  scoreboard_entry_t          decoded_instr_i,
    input  logic [31:0]                orig_instr_i,
    input  logic                       is_ctrl_flow_i,
    input  logic                       decoded_instr_valid_i,
    output logic                       decoded_instr_ack_o,
    output scoreboard_entry_t          issue_instr_o,
    output logic [31:0]                orig_instr_o,
    output logic                       is_ctrl_flow_o,
    output logic                       issue_instr_valid_o,
    input  logic                       issue_ack_i,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       ctrl_flow_pending_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam int unsigned CfW  = $clog2(MaxCtrlFlow + 1);

    localparam logic [CntW-1:0] DEPTH_C = CntW'(Depth);
    localparam logic [CfW-1:0]  MAXCF_C = CfW'(MaxCtrlFlow);

    // The configuration record carries nothing this block needs.
    logic unused_cfg;
    assign unused_cfg = ^CVA6Cfg;

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CfW-1:0]    cf_cnt_q, cf_cnt_d;

    scoreboard_entry_t entry_mem_q [Depth];
    scoreboard_entry_t entry_mem_d [Depth];
    logic [31:0]       orig_mem_q  [Depth];
    logic [31:0]       orig_mem_d  [Depth];
    logic              cf_mem_q    [Depth];
    logic              cf_mem_d    [Depth];

    logic full;
    logic cf_full;
    logic enq;
    logic deq;
    logic cf_enq;
    logic cf_deq;

    assign full    = (count_q == DEPTH_C);
    assign cf_full = (cf_cnt_q == MAXCF_C);

    // Ack is independent of valid; a full queue refuses even if the head leaves
    // this cycle, which keeps the ack path free of the issue-side handshake.
    assign decoded_instr_ack_o = !full && !flush_i && !rst_i
                                 && !(is_ctrl_flow_i && cf_full);

    assign issue_instr_valid_o = (count_q != '0) && !stall_i && !flush_i;

    assign enq    = decoded_instr_valid_i && decoded_instr_ack_o;
    assign deq    = issue_instr_valid_o && issue_ack_i;
    assign cf_enq = enq && is_ctrl_flow_i;
    assign cf_deq = deq && cf_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cf_cnt_d    = cf_cnt_q;
        entry_mem_d = entry_mem_q;
        orig_mem_d  = orig_mem_q;
        cf_mem_d    = cf_mem_q;

        if (enq) begin
            entry_mem_d[wr_ptr_q] = decoded_instr_i;
            orig_mem_d[wr_ptr_q]  = orig_instr_i;
            cf_mem_d[wr_ptr_q]    = is_ctrl_flow_i;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end

        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({cf_enq, cf_deq})
            2'b10:   cf_cnt_d = cf_cnt_q + 1'b1;
            2'b01:   cf_cnt_d = cf_cnt_q - 1'b1;
            default: cf_cnt_d = cf_cnt_q;
        endcase

        // Flush discards bookkeeping only; stale storage is unreachable once
        // count is zero. enq/deq are already blocked by flush_i.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            cf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cf_cnt_q    <= '0;
            entry_mem_q <= '{default: '0};
            orig_mem_q  <= '{default: '0};
            cf_mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cf_cnt_q    <= cf_cnt_d;
            entry_mem_q <= entry_mem_d;
            orig_mem_q  <= orig_mem_d;
            cf_mem_q    <= cf_mem_d;
        end
    end

    // Head storage is presented unconditionally; after reset it reads as zero.
    assign issue_instr_o       = entry_mem_q[rd_ptr_q];
    assign orig_instr_o        = orig_mem_q[rd_ptr_q];
    assign is_ctrl_flow_o      = cf_mem_q[rd_ptr_q];
    assign count_o             = count_q;
    assign ctrl_flow_pending_o = (cf_cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_q <= DEPTH_C);
            assert (cf_cnt_q <= MAXCF_C);
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;

    localparam int DEPTH = 4;
    localparam int MAXCF = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] dec_entry = '0;
    logic [31:0] dec_orig = '0;
    logic        dec_cf = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ack;
    logic [15:0] iss_entry;
    logic [31:0] iss_orig;
    logic        iss_cf;
    logic        iss_valid;
    logic        iss_ack = 1'b0;
    logic [2:0]  count;
    logic        pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    issue_queue #(
        .scoreboard_entry_t (logic [15:0]),
        .Depth              (DEPTH),
        .MaxCtrlFlow        (MAXCF)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .stall_i               (stall),
        .decoded_instr_i       (dec_entry),
        .orig_instr_i          (dec_orig),
        .is_ctrl_flow_i        (dec_cf),
        .decoded_instr_valid_i (dec_valid),
        .decoded_instr_ack_o   (dec_ack),
        .issue_instr_o         (iss_entry),
        .orig_instr_o          (iss_orig),
        .is_ctrl_flow_o        (iss_cf),
        .issue_instr_valid_o   (iss_valid),
        .issue_ack_i           (iss_ack),
        .count_o               (count),
        .ctrl_flow_pending_o   (pending)
    );

    // Reference model: the queue contents as an ordered list.
    typedef struct {
        logic [15:0] e;
        logic [31:0] o;
        logic        cf;
    } item_t;

    item_t mq[$];

    function automatic int m_cf_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i].cf) n++;
        return n;
    endfunction

    function automatic bit m_ack();
        return (mq.size() < DEPTH) && !flush && !rst && (!dec_cf || m_cf_cnt() < MAXCF);
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) && !stall && !flush;
    endfunction

    task automatic drive(input bit v, input logic [31:0] o, input bit cf,
                         input bit ia, input bit st, input bit fl);
        dec_valid = v;
        dec_orig  = o;
        dec_entry = o[15:0] ^ 16'h5A5A;
        dec_cf    = cf;
        iss_ack   = ia;
        stall     = st;
        flush     = fl;
    endtask

    // Advance one clock and update the model from the rules.
    task automatic tick();
        bit    enq;
        bit    deq;
        item_t it;
        enq  = dec_valid && m_ack();
        deq  = m_valid() && iss_ack;
        it.e = dec_entry;
        it.o = dec_orig;
        it.cf = dec_cf;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back(it);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 32'h1, 0, 0, 0, 0);
        #1;
        checks++;
        if (dec_ack !== 1'b0) begin failures++; $display("FAIL reset_ack_in_reset got %b exp 0", dec_ack); end
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", iss_valid); end
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++;
        if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got %b exp 0", pending); end
        checks++;
        if (iss_orig !== 32'h0 || iss_entry !== 16'h0 || iss_cf !== 1'b0) begin
            failures++; $display("FAIL reset_data got orig=%h entry=%h cf=%b exp 0", iss_orig, iss_entry, iss_cf);
        end
        checks++;
        if (dec_ack !== 1'b1) begin failures++; $display("FAIL reset_ack_after got %b exp 1", dec_ack); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'(i * 'h11), 0, 0, 0, 0);
            #1;
            checks++;
            if (dec_ack !== 1'b1) begin failures++; $display("FAIL fill_ack%0d got %b exp 1", i, dec_ack); end
            tick();
        end
        drive(1, 32'h55, 0, 0, 0, 0);
        #1;
        checks++;
        if (dec_ack !== 1'b0) begin failures++; $display("FAIL fill_ack5 got %b exp 0", dec_ack); end
        checks++;
        if (count !== 3'd4) begin failures++; $display("FAIL fill_count got %0d exp 4", count); end
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            #1;
            checks++;
            if (iss_valid !== 1'b1 || iss_orig !== 32'(i * 'h11)) begin
                failures++; $display("FAIL drain_head%0d got valid=%b orig=%h exp 1 %h", i, iss_valid, iss_orig, i * 'h11);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL drain_count got %0d exp 0", count); end
    endtask

    task automatic test_latency();
        drive(1, 32'hAA, 0, 1, 0, 0);
        #1;
        checks++;
        if (iss_valid !== 1'b0 || dec_ack !== 1'b1) begin
            failures++; $display("FAIL lat_same_cycle got valid=%b ack=%b exp 0 1", iss_valid, dec_ack);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (iss_valid !== 1'b1 || iss_orig !== 32'hAA) begin
            failures++; $display("FAIL lat_next_cycle got valid=%b orig=%h exp 1 aa", iss_valid, iss_orig);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL lat_dequeued got count=%0d exp 0", count); end
    endtask

    task automatic test_ctrl_flow();
        drive(1, 32'hB1, 1, 0, 0, 0);
        #1;
        checks++;
        if (dec_ack !== 1'b1) begin failures++; $display("FAIL cf_first_ack got %b exp 1", dec_ack); end
        tick();
        drive(1, 32'hB2, 1, 0, 0, 0);
        #1;
        checks++;
        if (dec_ack !== 1'b0 || pending !== 1'b1) begin
            failures++; $display("FAIL cf_second_blocked got ack=%b pending=%b exp 0 1", dec_ack, pending);
        end
        tick();
        drive(1, 32'hC1, 0, 0, 0, 0);
        #1;
        checks++;
        if (dec_ack !== 1'b1) begin failures++; $display("FAIL cf_alu_ack got %b exp 1", dec_ack); end
        tick();
        drive(1, 32'hB2, 1, 1, 0, 0);
        #1;
        checks++;
        if (iss_valid !== 1'b1 || iss_orig !== 32'hB1 || iss_cf !== 1'b1) begin
            failures++; $display("FAIL cf_head got valid=%b orig=%h cf=%b exp 1 b1 1", iss_valid, iss_orig, iss_cf);
        end
        checks++;
        if (dec_ack !== m_ack()) begin failures++; $display("FAIL cf_deq_cycle_ack got %b exp %b", dec_ack, m_ack()); end
        tick();
        drive(1, 32'hB2, 1, 0, 0, 0);
        #1;
        if (mq.size() == 1) begin
            checks++;
            if (dec_ack !== 1'b1 || pending !== 1'b0) begin
                failures++; $display("FAIL cf_second_accept got ack=%b pending=%b exp 1 0", dec_ack, pending);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 3'd2 || pending !== 1'b1) begin
            failures++; $display("FAIL cf_after got count=%0d pending=%b exp 2 1", count, pending);
        end
        drive(0, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (iss_orig !== 32'hC1) begin failures++; $display("FAIL cf_drain_c1 got %h exp c1", iss_orig); end
        tick();
        #0;
        checks++;
        if (iss_orig !== 32'hB2 || iss_cf !== 1'b1) begin
            failures++; $display("FAIL cf_drain_b2 got orig=%h cf=%b exp b2 1", iss_orig, iss_cf);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 3'd0 || pending !== 1'b0) begin
            failures++; $display("FAIL cf_empty got count=%0d pending=%b exp 0 0", count, pending);
        end
    endtask

    task automatic test_wrap();
        drive(1, 32'h100, 0, 0, 0, 0);
        tick();
        drive(1, 32'h101, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'(32'h102 + k), 0, 1, 0, 0);
            #1;
            checks++;
            if (dec_ack !== 1'b1 || iss_valid !== 1'b1 || iss_orig !== 32'(32'h100 + k) || count !== 3'd2) begin
                failures++;
                $display("FAIL wrap_%0d got ack=%b valid=%b orig=%h count=%0d exp 1 1 %h 2",
                         k, dec_ack, iss_valid, iss_orig, count, 32'h100 + k);
            end
            tick();
        end
        for (int k = 10; k < 12; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            #1;
            checks++;
            if (iss_orig !== 32'(32'h100 + k)) begin
                failures++; $display("FAIL wrap_drain_%0d got %h exp %h", k, iss_orig, 32'h100 + k);
            end
            tick();
        end
    endtask

    task automatic test_flush_stall();
        drive(1, 32'h301, 1, 0, 0, 0);
        tick();
        drive(1, 32'h302, 0, 0, 0, 0);
        tick();
        drive(1, 32'h303, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 0);
        #1;
        checks++;
        if (iss_valid !== 1'b0 || count !== 3'd3 || pending !== 1'b1) begin
            failures++; $display("FAIL stall got valid=%b count=%0d pending=%b exp 0 3 1", iss_valid, count, pending);
        end
        tick();
        drive(1, 32'h304, 0, 1, 0, 1);
        #1;
        checks++;
        if (dec_ack !== 1'b0 || iss_valid !== 1'b0) begin
            failures++; $display("FAIL flush_cycle got ack=%b valid=%b exp 0 0", dec_ack, iss_valid);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 3'd0 || pending !== 1'b0 || iss_valid !== 1'b0) begin
            failures++; $display("FAIL flush_after got count=%0d pending=%b valid=%b exp 0 0 0", count, pending, iss_valid);
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 32'h401, 1, 0, 0, 0);
        tick();
        drive(1, 32'h402, 0, 0, 0, 0);
        tick();
        drive(1, 32'h403, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (dec_ack !== 1'b0) begin failures++; $display("FAIL mrst_ack got %b exp 0", dec_ack); end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (count !== 3'd0 || iss_valid !== 1'b0 || pending !== 1'b0) begin
            failures++; $display("FAIL mrst_state got count=%0d valid=%b pending=%b exp 0 0 0", count, iss_valid, pending);
        end
        checks++;
        if (iss_orig !== 32'h0 || iss_entry !== 16'h0 || iss_cf !== 1'b0) begin
            failures++; $display("FAIL mrst_data got orig=%h entry=%h cf=%b exp 0", iss_orig, iss_entry, iss_cf);
        end
        checks++;
        if (dec_ack !== 1'b1) begin failures++; $display("FAIL mrst_ack_after got %b exp 1", dec_ack); end
        tick();
        #0;
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL mrst_not_stored got count=%0d exp 0", count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(63) == 0);
            flush     = ($urandom_range(15) == 0);
            stall     = ($urandom_range(3) == 0);
            dec_valid = ($urandom_range(3) != 0);
            dec_cf    = ($urandom_range(2) == 0);
            iss_ack   = ($urandom_range(1) == 0);
            dec_orig  = $urandom;
            dec_entry = 16'($urandom);
            #1;
            checks++;
            if (dec_ack !== m_ack()) begin failures++; $display("FAIL rnd_ack c=%0d got %b exp %b", c, dec_ack, m_ack()); end
            checks++;
            if (iss_valid !== m_valid()) begin failures++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, iss_valid, m_valid()); end
            checks++;
            if (count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count, mq.size()); end
            checks++;
            if (pending !== (m_cf_cnt() != 0)) begin
                failures++; $display("FAIL rnd_pending c=%0d got %b exp %b", c, pending, m_cf_cnt() != 0);
            end
            if (mq.size() != 0) begin
                checks++;
                if (iss_orig !== mq[0].o || iss_entry !== mq[0].e || iss_cf !== mq[0].cf) begin
                    failures++;
                    $display("FAIL rnd_head c=%0d got %h/%h/%b exp %h/%h/%b",
                             c, iss_orig, iss_entry, iss_cf, mq[0].o, mq[0].e, mq[0].cf);
                end
            end
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_latency();
        test_ctrl_flow();
        test_wrap();
        test_flush_stall();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
